// File: rtl/vc_arbiter_pkg.sv
// rtl/vc_arbiter_pkg.sv - shared sizes, destination field and FSM encoding for vc_arbiter
package vc_arbiter_pkg;

    localparam int N_IN    = 4;
    localparam int DATA_W  = 6;
    localparam int IDX_W   = 2;
    localparam int DST_MSB = 5;
    localparam int DST_LSB = 4;
    localparam int DST_W   = DST_MSB - DST_LSB + 1;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    function automatic logic [N_IN-1:0] dst_onehot(input logic [DST_W-1:0] dst);
        return N_IN'(1) << dst;
    endfunction

endpackage

// File: rtl/vc_arbiter_rr_pick.sv
// rtl/vc_arbiter_rr_pick.sv - combinational round-robin picker, search starts after last_grant
module rr_pick
    import vc_arbiter_pkg::*;
(
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_IN-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] cand;

    // N_IN is a power of two, so the IDX_W-bit add wraps 3 -> 0 by itself
    always_comb begin
        grant       = '0;
        grant_idx   = last_grant;
        grant_valid = 1'b0;
        cand        = last_grant;
        for (int k = 1; k <= N_IN; k++) begin
            cand = last_grant + IDX_W'(k);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_arbiter.sv
// rtl/vc_arbiter.sv - round-robin source-to-destination FIFO arbiter; VC_ARBITER_STATS_EN adds push counters
module vc_arbiter #(
    parameter int N_IN   = vc_arbiter_pkg::N_IN,
    parameter int DATA_W = vc_arbiter_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_IN*DATA_W-1:0] src_data,
    input  logic [N_IN-1:0]        src_empty,
    output logic [N_IN-1:0]        src_pop,
    input  logic [N_IN-1:0]        dst_almost_full,
    input  logic [N_IN-1:0]        dst_full,
    output logic [N_IN-1:0]        dst_push,
    output logic [DATA_W-1:0]      dst_data,
    output logic                   arb_error,
    output logic [4*8-1:0]         push_cnt
);
    import vc_arbiter_pkg::*;

    state_t            state;
    state_t            next_state;
    logic [N_IN-1:0]   eligible;
    logic [N_IN-1:0]   grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_valid;
    logic [IDX_W-1:0]  last_grant;
    logic [DATA_W-1:0] grant_word;
    logic [DST_W-1:0]  grant_dst;
    logic [N_IN-1:0]   push_sel;

    // A source is skipped, not waited on, when its own target is almost full
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_IN; i++) begin
            eligible[i] = !src_empty[i] &&
                          !dst_almost_full[src_data[i*DATA_W + DST_LSB +: DST_W]];
        end
    end

    rr_pick u_pick (
        .req         (eligible),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign grant_word = src_data[grant_idx*DATA_W +: DATA_W];
    assign grant_dst  = grant_word[DST_MSB:DST_LSB];

    always_comb begin
        next_state = ST_IDLE;
        src_pop    = '0;
        if (grant_valid) begin
            next_state = ST_ACTIVE;
        end else if (!(&src_empty)) begin
            next_state = ST_BLOCKED;
        end
        if (reset) begin
            src_pop = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(N_IN - 1);
            push_sel   <= '0;
            dst_data   <= '0;
            arb_error  <= 1'b0;
        end else begin
            state     <= next_state;
            arb_error <= grant_valid && dst_full[grant_dst];
            if (grant_valid) begin
                last_grant <= grant_idx;
                dst_data   <= grant_word;
                push_sel   <= dst_onehot(grant_dst);
            end
        end
    end

    // ACTIVE is held exactly for the cycle following a grant, i.e. the push cycle
    assign dst_push = (state == ST_ACTIVE) ? push_sel : '0;

`ifdef VC_ARBITER_STATS_EN
    logic [CNT_W-1:0] cnt [N_IN];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < N_IN; j++) cnt[j] <= '0;
        end else begin
            for (int j = 0; j < N_IN; j++) begin
                if (dst_push[j] && cnt[j] != {CNT_W{1'b1}}) cnt[j] <= cnt[j] + 1'b1;
            end
        end
    end

    always_comb begin
        push_cnt = '0;
        for (int j = 0; j < N_IN; j++) push_cnt[j*CNT_W +: CNT_W] = cnt[j];
    end
`else
    assign push_cnt = '0;
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// tb/tb_vc_arbiter.sv - directed and randomized self-checking bench for vc_arbiter
module tb_vc_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] src_data;
    logic [3:0]  src_empty;
    logic [3:0]  src_pop;
    logic [3:0]  dst_almost_full;
    logic [3:0]  dst_full;
    logic [3:0]  dst_push;
    logic [5:0]  dst_data;
    logic        arb_error;
    logic [31:0] push_cnt;

    int checks = 0;
    int errors = 0;

    vc_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .src_data        (src_data),
        .src_empty       (src_empty),
        .src_pop         (src_pop),
        .dst_almost_full (dst_almost_full),
        .dst_full        (dst_full),
        .dst_push        (dst_push),
        .dst_data        (dst_data),
        .arb_error       (arb_error),
        .push_cnt        (push_cnt)
    );

    always #5 clk = ~clk;

`ifdef VC_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // reference model state
    int          m_lg;
    logic [3:0]  m_push;
    logic [5:0]  m_data;
    logic        m_err;
    logic        m_full_grant;
    int          m_err_dst;
    int          m_cnt [4];
    logic [1:0]  m_state;
    logic [3:0]  exp_pop;

    task automatic drive(input logic [23:0] d, input logic [3:0] e, input logic [3:0] af,
                         input logic [3:0] f, input logic r);
        @(negedge clk);
        src_data        = d;
        src_empty       = e;
        dst_almost_full = af;
        dst_full        = f;
        reset           = r;
        #1;
    endtask

    function automatic logic [5:0] word(input int i);
        return src_data[i*6 +: 6];
    endfunction

    function automatic int ref_pick();
        for (int k = 1; k <= 4; k++) begin
            int i;
            logic [5:0] w;
            i = (m_lg + k) % 4;
            w = word(i);
            if (!src_empty[i] && !dst_almost_full[w[5:4]]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_cnt_packed();
        logic [31:0] p;
        p = '0;
        for (int j = 0; j < 4; j++) p[j*8 +: 8] = STATS ? 8'(m_cnt[j]) : 8'd0;
        return p;
    endfunction

    task automatic model_step();
        int g;
        logic [5:0] w;
        g = reset ? ref_pick() : -1;
        exp_pop = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        if (!reset) begin
            m_lg = 3; m_push = '0; m_err = 1'b0; m_state = 2'd0;
            for (int j = 0; j < 4; j++) m_cnt[j] = 0;
        end else begin
            for (int j = 0; j < 4; j++) if (m_push[j] && m_cnt[j] < 255) m_cnt[j]++;
            if (g >= 0) begin
                w = word(g);
                m_lg = g;
                m_push = 4'b0001 << w[5:4];
                m_data = w;
                m_err_dst = int'(w[5:4]);
                m_full_grant = dst_full[w[5:4]];
                m_err = m_full_grant;
                m_state = 2'd1;
            end else begin
                m_push = '0;
                m_err = 1'b0;
                m_state = (&src_empty) ? 2'd0 : 2'd2;
            end
        end
    endtask

    task automatic test_reset();
        drive(24'hFFFFFF, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        drive(24'hFFFFFF, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checks++; if (src_pop !== 4'b0) begin errors++; $display("FAIL reset_pop got %b expected 0000", src_pop); end
        checks++; if (dst_push !== 4'b0) begin errors++; $display("FAIL reset_push got %b expected 0000", dst_push); end
        checks++; if (dst_data !== 6'h0) begin errors++; $display("FAIL reset_data got %h expected 00", dst_data); end
        checks++; if (arb_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", arb_error); end
        checks++; if (push_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h expected 0", push_cnt); end
    endtask

    task automatic test_basic();
        logic [23:0] d;
        d = {6'h00, 6'b10_0101, 6'h00, 6'b01_0011};
        drive(d, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        drive(d, 4'b1010, 4'b0000, 4'b0000, 1'b1);
        checks++; if (src_pop !== 4'b0001) begin errors++; $display("FAIL basic_pop1 got %b expected 0001", src_pop); end
        drive(d, 4'b1011, 4'b0000, 4'b0000, 1'b1);
        checks++; if (dst_push !== 4'b0010) begin errors++; $display("FAIL basic_push1 got %b expected 0010", dst_push); end
        checks++; if (dst_data !== 6'h13) begin errors++; $display("FAIL basic_data1 got %h expected 13", dst_data); end
        checks++; if (src_pop !== 4'b0100) begin errors++; $display("FAIL basic_pop2 got %b expected 0100", src_pop); end
        drive(d, 4'b1111, 4'b0000, 4'b0000, 1'b1);
        checks++; if (dst_push !== 4'b0100) begin errors++; $display("FAIL basic_push2 got %b expected 0100", dst_push); end
        checks++; if (dst_data !== 6'h25) begin errors++; $display("FAIL basic_data2 got %h expected 25", dst_data); end
        checks++; if (src_pop !== 4'b0000) begin errors++; $display("FAIL basic_pop3 got %b expected 0000", src_pop); end
    endtask

    task automatic test_round_robin();
        logic [23:0] d;
        logic [5:0]  prev;
        d = 24'($urandom);
        prev = '0;
        drive(d, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(d, 4'b0000, 4'b0000, 4'b0000, 1'b1);
            checks++;
            if (src_pop !== (4'b0001 << (c % 4))) begin
                errors++; $display("FAIL rr_pop%0d got %b expected %b", c, src_pop, 4'b0001 << (c % 4));
            end
            if (c > 0) begin
                checks++;
                if (dst_push !== (4'b0001 << prev[5:4]) || dst_data !== prev) begin
                    errors++; $display("FAIL rr_push%0d got %b/%h expected %b/%h", c, dst_push, dst_data,
                                       4'b0001 << prev[5:4], prev);
                end
            end
            prev = d[(c % 4)*6 +: 6];
        end
    endtask

    task automatic test_almost_full();
        logic [23:0] d;
        d = {6'h00, 6'b00_1010, 6'b11_0110, 6'h00};
        drive(d, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        drive(d, 4'b1001, 4'b1000, 4'b0000, 1'b1);
        checks++; if (src_pop !== 4'b0100) begin errors++; $display("FAIL af_skip got %b expected 0100", src_pop); end
        drive(d, 4'b1101, 4'b1000, 4'b0000, 1'b1);
        checks++; if (src_pop !== 4'b0000) begin errors++; $display("FAIL af_hold got %b expected 0000", src_pop); end
        drive(d, 4'b1101, 4'b1000, 4'b0000, 1'b1);
        checks++; if (dut.state !== 2'd2) begin errors++; $display("FAIL af_state got %0d expected 2", dut.state); end
        drive(d, 4'b1101, 4'b0000, 4'b0000, 1'b1);
        checks++; if (src_pop !== 4'b0010) begin errors++; $display("FAIL af_release got %b expected 0010", src_pop); end
    endtask

    task automatic test_error();
        logic [23:0] d;
        d = {18'h0, 6'b00_0111};
        drive(d, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        drive(d, 4'b1110, 4'b0000, 4'b0001, 1'b1);
        checks++; if (src_pop !== 4'b0001 || arb_error !== 1'b0) begin
            errors++; $display("FAIL err_grant got %b/%b expected 0001/0", src_pop, arb_error); end
        drive(d, 4'b1111, 4'b0000, 4'b0001, 1'b1);
        checks++; if (dst_push !== 4'b0001 || arb_error !== 1'b1) begin
            errors++; $display("FAIL err_push got %b/%b expected 0001/1", dst_push, arb_error); end
        drive(d, 4'b1111, 4'b0000, 4'b0001, 1'b1);
        checks++; if (arb_error !== 1'b0) begin errors++; $display("FAIL err_clear got %b expected 0", arb_error); end
    endtask

    task automatic test_reset_in_flight();
        logic [23:0] d;
        d = 24'($urandom);
        drive(d, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        drive(d, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        drive(d, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        drive(d, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        checks++; if (src_pop !== 4'b0000) begin errors++; $display("FAIL rif_pop got %b expected 0000", src_pop); end
        drive(d, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        checks++; if (dst_push !== 4'b0000) begin errors++; $display("FAIL rif_push got %b expected 0000", dst_push); end
        checks++; if (src_pop !== 4'b0001) begin errors++; $display("FAIL rif_first got %b expected 0001", src_pop); end
    endtask

    task automatic test_stats();
        logic [23:0] d;
        logic [31:0] exp_cnt;
        int bad;
        bad = 0;
        drive(24'h0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        for (int c = 0; c < 300; c++) begin
            d = {6'h00, 2'b10, 4'($urandom), 12'h000};
            drive(d, 4'b1011, 4'b0000, 4'b0000, 1'b1);
            if (src_pop !== 4'b0100) bad++;
            if (!STATS && push_cnt !== 32'h0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stats_loop got %0d bad cycles expected 0", bad); end
        drive(24'h0, 4'b1111, 4'b0000, 4'b0000, 1'b1);
        drive(24'h0, 4'b1111, 4'b0000, 4'b0000, 1'b1);
        exp_cnt = STATS ? 32'h00FF_0000 : 32'h0;
        checks++; if (push_cnt !== exp_cnt) begin errors++; $display("FAIL stats_sat got %h expected %h", push_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        logic [3:0] f;
        logic       r;
        f = '0;
        drive(24'h0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        model_step();
        for (int c = 0; c < 500; c++) begin
            if (c % 16 == 0) f = 4'($urandom) & 4'($urandom);
            r = ($urandom_range(0, 39) != 0);
            drive(24'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom), f, r);
            checks++;
            if (dst_push !== m_push) begin errors++; $display("FAIL rnd_push c%0d got %b expected %b", c, dst_push, m_push); end
            if (m_push != 0) begin
                checks++;
                if (dst_data !== m_data) begin errors++; $display("FAIL rnd_data c%0d got %h expected %h", c, dst_data, m_data); end
            end
            if (m_push == 0 || dst_full[m_err_dst] === m_full_grant) begin
                checks++;
                if (arb_error !== m_err) begin errors++; $display("FAIL rnd_err c%0d got %b expected %b", c, arb_error, m_err); end
            end
            checks++;
            if (push_cnt !== m_cnt_packed()) begin errors++; $display("FAIL rnd_cnt c%0d got %h expected %h", c, push_cnt, m_cnt_packed()); end
            checks++;
            if (dut.state !== m_state) begin errors++; $display("FAIL rnd_state c%0d got %0d expected %0d", c, dut.state, m_state); end
            model_step();
            checks++;
            if (src_pop !== exp_pop) begin errors++; $display("FAIL rnd_pop c%0d got %b expected %b", c, src_pop, exp_pop); end
            checks++;
            if ((src_pop & src_empty) !== 4'b0) begin errors++; $display("FAIL rnd_pop_empty c%0d got %b expected 0000", c, src_pop & src_empty); end
        end
    endtask

    initial begin
        reset = 1'b0; src_data = '0; src_empty = '1; dst_almost_full = '0; dst_full = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_almost_full();
        test_error();
        test_reset_in_flight();
        test_stats();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
